// File: rtl/mbc3_rtc_bk_reader_if.sv
// Backup-word stream between the MBC3 RTC write-back reader and the save-file writer.
interface mbc3_rtc_bk_reader_if;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_addr;
    logic [15:0] out_data;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/mbc3_rtc_bk_reader.sv
// Snapshots the live MBC3 RTC timestamp/registers and streams them as 16-bit backup words.
// Optional build macro MBC3_RTC_BK_CHECKSUM_EN appends a checksum word at address 5.
module mbc3_rtc_bk_reader #(
    parameter int MAX_RESAMPLE = 4
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          save_req,
    input  logic                          rtc_inuse,
    input  logic [31:0]                   rtc_timestamp,
    input  logic [31:0]                   rtc_savedtime,
    mbc3_rtc_bk_reader_if.master          out_if,
    output logic                          busy,
    output logic                          done,
    output logic                          skipped
);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        CHECK,
        SEND,
        DONE
    } state_t;

`ifdef MBC3_RTC_BK_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd5;
`else
    localparam logic [2:0] LAST_IDX = 3'd4;
`endif
    localparam logic [3:0] RETRY_LAST = 4'(MAX_RESAMPLE - 1);

    state_t      state_q, state_d;
    logic [31:0] snap_ts_q, snap_ts_d;
    logic [31:0] snap_st_q, snap_st_d;
    logic [3:0]  retry_q, retry_d;
    logic [2:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        skipped_q, skipped_d;

    function automatic logic [15:0] word_sel(input logic [31:0] ts,
                                             input logic [31:0] st,
                                             input logic [2:0]  idx);
        logic [15:0] w;
        case (idx)
            3'd0:    w = ts[15:0];
            3'd1:    w = ts[31:16];
            3'd2:    w = st[15:0];
            3'd3:    w = st[31:16];
`ifdef MBC3_RTC_BK_CHECKSUM_EN
            3'd5:    w = ~(ts[15:0] ^ ts[31:16] ^ st[15:0] ^ st[31:16]);
`endif
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            snap_ts_q <= '0;
            snap_st_q <= '0;
            retry_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            skipped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_ts_q <= snap_ts_d;
            snap_st_q <= snap_st_d;
            retry_q   <= retry_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            skipped_q <= skipped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        snap_ts_d = snap_ts_q;
        snap_st_d = snap_st_q;
        retry_d   = retry_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        data_d    = data_q;
        skipped_d = skipped_q;

        if (!enable) begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            skipped_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (save_req) begin
                        if (rtc_inuse) begin
                            state_d = SAMPLE;
                        end else begin
                            state_d   = DONE;
                            skipped_d = 1'b1;
                        end
                    end
                end
                SAMPLE: begin
                    snap_ts_d = rtc_timestamp;
                    snap_st_d = rtc_savedtime;
                    retry_d   = '0;
                    state_d   = CHECK;
                end
                CHECK: begin
                    if (rtc_timestamp == snap_ts_q && rtc_savedtime == snap_st_q) begin
                        state_d = SEND;
                        idx_d   = 3'd0;
                        valid_d = 1'b1;
                        addr_d  = 8'd0;
                        data_d  = word_sel(snap_ts_q, snap_st_q, 3'd0);
                    end else begin
                        // Every mismatch recaptures; the MAX_RESAMPLE-th recapture is taken as-is.
                        snap_ts_d = rtc_timestamp;
                        snap_st_d = rtc_savedtime;
                        retry_d   = retry_q + 4'd1;
                        if (retry_q == RETRY_LAST) begin
                            state_d = SEND;
                            idx_d   = 3'd0;
                            valid_d = 1'b1;
                            addr_d  = 8'd0;
                            data_d  = word_sel(rtc_timestamp, rtc_savedtime, 3'd0);
                        end
                    end
                end
                SEND: begin
                    if (out_if.out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            valid_d = 1'b0;
                            state_d = DONE;
                        end else begin
                            idx_d  = idx_q + 3'd1;
                            addr_d = {5'd0, idx_q + 3'd1};
                            data_d = word_sel(snap_ts_q, snap_st_q, idx_q + 3'd1);
                        end
                    end
                end
                DONE: begin
                    skipped_d = 1'b0;
                    state_d   = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_addr  = addr_q;
    assign out_if.out_data  = data_q;
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign skipped          = skipped_q;

endmodule
